// File: rtl/instruction_fetch_if.sv
// Memory read port and instruction handshake between instruction_fetch (master)
// and the memory / control unit on the other side (slave).
interface instruction_fetch_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic [15:0] instr_next_pc;
    logic        instr_illegal;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_opcode,
        output instr_operand,
        output instr_len,
        output instr_pc,
        output instr_next_pc,
        output instr_illegal
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_opcode,
        input  instr_operand,
        input  instr_len,
        input  instr_pc,
        input  instr_next_pc,
        input  instr_illegal
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads opcode and 0-2 operand bytes from memory and presents
// the complete instruction to the control unit on a valid/ready handshake.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        bus,
    input  logic                       pc_load,
    input  logic [15:0]                pc_new
);

    typedef enum logic [2:0] {
        StFetchOp,
        StLatchOp,
        StFetchLo,
        StLatchLo,
        StFetchHi,
        StLatchHi,
        StValid
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;

    // Returns {illegal, len}.
    function automatic logic [2:0] decode(input logic [7:0] op);
        logic [2:0] res;
        if (op[1:0] == 2'b01) begin
            unique case (op[4:2])
                3'b011, 3'b110, 3'b111: res = {1'b0, 2'd3};
                default:                res = {1'b0, 2'd2};
            endcase
        end else if (op[4:0] == 5'b10010) begin
            res = {1'b0, 2'd2};
        end else begin
            res = {1'b1, 2'd1};
        end
        return res;
    endfunction

    logic [2:0]  dec_cur;
    logic [2:0]  dec_rdata;
    logic [1:0]  cur_len;
    logic [15:0] next_pc;

    assign dec_cur   = decode(opcode_q);
    assign dec_rdata = decode(bus.mem_rdata);
    assign cur_len   = dec_cur[1:0];
    assign next_pc   = pc_q + {14'b0, cur_len};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StFetchOp;
            pc_q     <= RESET_PC;
            opcode_q <= 8'h00;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        unique case (state_q)
            StFetchOp: begin
                opcode_d = 8'h00;
                lo_d     = 8'h00;
                hi_d     = 8'h00;
                state_d  = StLatchOp;
            end
            StLatchOp: begin
                opcode_d = bus.mem_rdata;
                state_d  = (dec_rdata[1:0] >= 2'd2) ? StFetchLo : StValid;
            end
            StFetchLo: state_d = StLatchLo;
            StLatchLo: begin
                lo_d    = bus.mem_rdata;
                state_d = (cur_len == 2'd3) ? StFetchHi : StValid;
            end
            StFetchHi: state_d = StLatchHi;
            StLatchHi: begin
                hi_d    = bus.mem_rdata;
                state_d = StValid;
            end
            StValid: begin
                if (bus.instr_ready) begin
                    pc_d    = next_pc;
                    state_d = StFetchOp;
                end
            end
            default: state_d = StFetchOp;
        endcase
        // A redirect overrides everything, including an accept and any byte in flight.
        if (pc_load) begin
            pc_d     = pc_new;
            state_d  = StFetchOp;
            opcode_d = opcode_q;
            lo_d     = lo_q;
            hi_d     = hi_q;
        end
    end

    // Gated by reset so the strobe is quiet while held in reset yet fires the first clock after.
    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_addr = 16'h0000;
        if (reset) begin
            unique case (state_q)
                StFetchOp: begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = pc_q;
                end
                StFetchLo: begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = pc_q + 16'd1;
                end
                StFetchHi: begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = pc_q + 16'd2;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.instr_valid   = 1'b0;
        bus.instr_opcode  = 8'h00;
        bus.instr_operand = 16'h0000;
        bus.instr_len     = 2'd0;
        bus.instr_pc      = 16'h0000;
        bus.instr_next_pc = 16'h0000;
        bus.instr_illegal = 1'b0;
        if (state_q == StValid) begin
            bus.instr_valid   = 1'b1;
            bus.instr_opcode  = opcode_q;
            bus.instr_operand = {hi_q, lo_q};
            bus.instr_len     = cur_len;
            bus.instr_pc      = pc_q;
            bus.instr_next_pc = next_pc;
            bus.instr_illegal = dec_cur[2];
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a behavioural byte memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_new = 16'h0000;

    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(16'h0200)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pc_load (pc_load),
        .pc_new  (pc_new)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log [$];
    int          tests = 0;
    int          fails = 0;

    // Read data is valid one cycle after the strobe; junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_log.push_back(bus.mem_addr);
        end else begin
            bus.mem_rdata <= 8'h5A;
        end
    end

    function automatic logic [58:0] fields();
        return {bus.instr_opcode, bus.instr_operand, bus.instr_len, bus.instr_pc,
                bus.instr_next_pc, bus.instr_illegal};
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [58:0] got;
        repeat (2) @(negedge clk);
        got = fields();
        tests++;
        if ({bus.mem_rd, bus.mem_addr, bus.instr_valid} !== 18'h0) begin
            fails++;
            $display("FAIL reset_bus: got rd=%b addr=%h valid=%b, want 0", bus.mem_rd,
                     bus.mem_addr, bus.instr_valid);
        end
        tests++;
        if (got !== 59'h0) begin
            fails++;
            $display("FAIL reset_fields: got %h want 0", got);
        end
    endtask

    task automatic test_two_byte();
        int n, base;
        logic [58:0] got, exp;
        reset = 1'b1;
        #1;
        base = rd_log.size();
        tests++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0200) begin
            fails++;
            $display("FAIL first_read: got rd=%b addr=%h want 1/0200", bus.mem_rd, bus.mem_addr);
        end
        wait_valid(n);
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL lat_len2: got %0d want 4", n);
        end
        exp = {8'h69, 16'h0005, 2'd2, 16'h0200, 16'h0202, 1'b0};
        got = fields();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL fields_69: got %h want %h", got, exp);
        end
        tests++;
        if (rd_log.size() - base !== 2 || rd_log[base] !== 16'h0200 || rd_log[base+1] !== 16'h0201)
        begin
            fails++;
            $display("FAIL reads_69: got %0d reads, want 0200,0201", rd_log.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = fields();
            tests++;
            if (bus.instr_valid !== 1'b1 || got !== exp) begin
                fails++;
                $display("FAIL hold_%0d: got valid=%b %h want 1 %h", i, bus.instr_valid, got, exp);
            end
        end
        accept();
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0202) begin
            fails++;
            $display("FAIL after_accept: got valid=%b rd=%b addr=%h want 0/1/0202",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_three_byte();
        int n;
        logic [58:0] got, exp;
        wait_valid(n);
        tests++;
        if (n !== 6) begin
            fails++;
            $display("FAIL lat_len3: got %0d want 6", n);
        end
        exp = {8'h6D, 16'h1234, 2'd3, 16'h0202, 16'h0205, 1'b0};
        got = fields();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL fields_6d: got %h want %h", got, exp);
        end
        accept();
        tests++;
        if (bus.mem_addr !== 16'h0205) begin
            fails++;
            $display("FAIL next_0205: got %h want 0205", bus.mem_addr);
        end
    endtask

    task automatic test_zp_ind_and_illegal();
        int n;
        logic [58:0] got, exp;
        wait_valid(n);
        exp = {8'h72, 16'h0080, 2'd2, 16'h0205, 16'h0207, 1'b0};
        got = fields();
        tests++;
        if (n !== 4 || got !== exp) begin
            fails++;
            $display("FAIL fields_72: got lat=%0d %h want 4 %h", n, got, exp);
        end
        accept();
        wait_valid(n);
        tests++;
        if (n !== 2) begin
            fails++;
            $display("FAIL lat_len1: got %0d want 2", n);
        end
        exp = {8'hEA, 16'h0000, 2'd1, 16'h0207, 16'h0208, 1'b1};
        got = fields();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL fields_ea: got %h want %h", got, exp);
        end
    endtask

    task automatic test_wrap();
        int n, base;
        logic [58:0] got, exp;
        pc_load = 1'b1;
        pc_new  = 16'hFFFE;
        @(negedge clk);
        pc_load = 1'b0;
        base = rd_log.size();
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'hFFFE) begin
            fails++;
            $display("FAIL redirect_fffe: got valid=%b rd=%b addr=%h want 0/1/FFFE",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        wait_valid(n);
        exp = {8'h7D, 16'hABCD, 2'd3, 16'hFFFE, 16'h0001, 1'b0};
        got = fields();
        tests++;
        if (n !== 6 || got !== exp) begin
            fails++;
            $display("FAIL fields_wrap: got lat=%0d %h want 6 %h", n, got, exp);
        end
        tests++;
        if (rd_log.size() - base !== 3 || rd_log[base] !== 16'hFFFE ||
            rd_log[base+1] !== 16'hFFFF || rd_log[base+2] !== 16'h0000) begin
            fails++;
            $display("FAIL reads_wrap: got %0d reads, want FFFE,FFFF,0000", rd_log.size() - base);
        end
        accept();
        tests++;
        if (bus.mem_addr !== 16'h0001) begin
            fails++;
            $display("FAIL next_0001: got %h want 0001", bus.mem_addr);
        end
    endtask

    task automatic test_redirect_mid();
        int n;
        logic [58:0] got, exp;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL latch_lo_idle: got rd=%b valid=%b want 0/0", bus.mem_rd,
                     bus.instr_valid);
        end
        pc_load = 1'b1;
        pc_new  = 16'h0300;
        @(negedge clk);
        pc_load = 1'b0;
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0300) begin
            fails++;
            $display("FAIL redirect_0300: got valid=%b rd=%b addr=%h want 0/1/0300",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        wait_valid(n);
        exp = {8'hA9, 16'h0042, 2'd2, 16'h0300, 16'h0302, 1'b0};
        got = fields();
        tests++;
        if (n !== 4 || got !== exp) begin
            fails++;
            $display("FAIL fields_a9: got lat=%0d %h want 4 %h", n, got, exp);
        end
    endtask

    task automatic test_load_and_ready();
        pc_load = 1'b1;
        pc_new  = 16'h0400;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        bus.instr_ready = 1'b0;
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0400) begin
            fails++;
            $display("FAIL load_wins: got valid=%b rd=%b addr=%h want 0/1/0400",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [58:0] got, exp;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        got = fields();
        tests++;
        if ({bus.mem_rd, bus.mem_addr, bus.instr_valid} !== 18'h0 || got !== 59'h0) begin
            fails++;
            $display("FAIL reset_mid: got rd=%b addr=%h valid=%b %h want all 0", bus.mem_rd,
                     bus.mem_addr, bus.instr_valid, got);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0200) begin
            fails++;
            $display("FAIL restart: got rd=%b addr=%h want 1/0200", bus.mem_rd, bus.mem_addr);
        end
        wait_valid(n);
        exp = {8'h69, 16'h0005, 2'd2, 16'h0200, 16'h0202, 1'b0};
        got = fields();
        tests++;
        if (n !== 4 || got !== exp) begin
            fails++;
            $display("FAIL fields_restart: got lat=%0d %h want 4 %h", n, got, exp);
        end
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
        mem[16'h0200] = 8'h69; mem[16'h0201] = 8'h05;
        mem[16'h0202] = 8'h6D; mem[16'h0203] = 8'h34; mem[16'h0204] = 8'h12;
        mem[16'h0205] = 8'h72; mem[16'h0206] = 8'h80;
        mem[16'h0207] = 8'hEA;
        mem[16'hFFFE] = 8'h7D; mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
        mem[16'h0001] = 8'h6D; mem[16'h0002] = 8'h11; mem[16'h0003] = 8'h22;
        mem[16'h0300] = 8'hA9; mem[16'h0301] = 8'h42;
        mem[16'h0400] = 8'h6D; mem[16'h0401] = 8'h55; mem[16'h0402] = 8'h66;

        test_reset();
        test_two_byte();
        test_three_byte();
        test_zp_ind_and_illegal();
        test_wrap();
        test_redirect_mid();
        test_load_and_ready();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
